// File: rtl/dma_rd_arbiter_if.sv
// Bundle of requester-side and read-engine-side signals around dma_rd_arbiter.
// slave is the arbiter's view; master is the view of whatever drives requests and DMA completion.
interface dma_rd_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int AW         = 32,
    parameter int BITS_TRANS = 8,
    parameter int BLK_W      = 16
);
    logic [NUM_REQ-1:0]       i_req_valid;
    logic [NUM_REQ*AW-1:0]    i_req_addr;
    logic [NUM_REQ*BLK_W-1:0] i_req_nblk;
    logic [NUM_REQ-1:0]       o_req_ready;
    logic [NUM_REQ-1:0]       o_req_done;
    logic [NUM_REQ-1:0]       o_grant;
    logic                     o_busy;
    logic                     o_start_dma;
    logic [AW-1:0]            o_start_addr;
    logic [BITS_TRANS-1:0]    o_num_trans;
    logic                     i_dma_done;

    modport slave (
        input  i_req_valid, i_req_addr, i_req_nblk, i_dma_done,
        output o_req_ready, o_req_done, o_grant, o_busy,
        output o_start_dma, o_start_addr, o_num_trans
    );

    modport master (
        output i_req_valid, i_req_addr, i_req_nblk, i_dma_done,
        input  o_req_ready, o_req_done, o_grant, o_busy,
        input  o_start_dma, o_start_addr, o_num_trans
    );
endinterface

// File: rtl/dma_rd_arbiter.sv
// Round-robin arbiter sharing one DMA read engine among NUM_REQ block-read loaders.
// Define DMA_ARB_INTERLEAVE_EN for burst-level interleaving (per-requester slot registers).
module dma_rd_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int AW             = 32,
    parameter int BITS_TRANS     = 8,
    parameter int NUM_TRANS      = 16,
    parameter int BYTES_PER_BEAT = 4,
    parameter int BLK_W          = 16
) (
    input logic              clk,
    input logic              rst,
    dma_rd_arbiter_if.slave  bus
);
    localparam int LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [AW-1:0] BURST_BYTES = AW'(NUM_TRANS * BYTES_PER_BEAT);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    logic [1:0]         state;
    logic [LW-1:0]      last;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] ready;
    logic [NUM_REQ-1:0] done;
    logic [AW-1:0]      cur_addr;
    logic [BLK_W-1:0]   cur_rem;

    logic [NUM_REQ-1:0] cand;
    logic               found;
    logic [LW-1:0]      win;
    logic [NUM_REQ-1:0] win_hot;
    logic [AW-1:0]      win_addr;
    logic [BLK_W-1:0]   win_nblk;
    logic [AW-1:0]      new_addr;
    logic [BLK_W-1:0]   new_rem;
    logic               arb_point;

    assign new_addr = cur_addr + BURST_BYTES;
    assign new_rem  = cur_rem - BLK_W'(1);

`ifdef DMA_ARB_INTERLEAVE_EN
    logic [NUM_REQ-1:0] slot_active;
    logic [AW-1:0]      slot_addr [NUM_REQ];
    logic [BLK_W-1:0]   slot_rem  [NUM_REQ];
    logic [LW-1:0]      owner;
    logic [NUM_REQ-1:0] fin_mask;
    logic               cont;

    // A slot finishing on this done must not compete as an active slot.
    assign fin_mask  = (state == WAIT && bus.i_dma_done && cur_rem == BLK_W'(1)) ? grant : '0;
    assign cand      = (slot_active & ~fin_mask) | bus.i_req_valid;
    assign arb_point = (state == IDLE) || (state == WAIT && bus.i_dma_done);
    assign cont      = (state == WAIT) && (win == owner) && !fin_mask[win];
`else
    assign cand      = bus.i_req_valid;
    assign arb_point = (state == IDLE);
`endif

    always_comb begin
        int idx;
        found = 1'b0;
        win   = last;
        idx   = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = int'(last) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = LW'(idx);
            end
        end
    end

    assign win_hot  = NUM_REQ'(1) << win;
    assign win_addr = bus.i_req_addr[int'(win)*AW +: AW];
    assign win_nblk = bus.i_req_nblk[int'(win)*BLK_W +: BLK_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            last     <= LW'(NUM_REQ - 1);
            grant    <= '0;
            ready    <= '0;
            done     <= '0;
            cur_addr <= '0;
            cur_rem  <= '0;
`ifdef DMA_ARB_INTERLEAVE_EN
            slot_active <= '0;
            owner       <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                slot_addr[i] <= '0;
                slot_rem[i]  <= '0;
            end
`endif
        end else begin
            ready <= '0;
            done  <= '0;
            case (state)
                IDLE: ;
                ISSUE: begin
                    // A zero-length request skips the engine and completes directly.
                    if (cur_rem == '0) begin
                        done  <= grant;
                        grant <= '0;
                        state <= IDLE;
`ifdef DMA_ARB_INTERLEAVE_EN
                        slot_active[owner] <= 1'b0;
`endif
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.i_dma_done) begin
                        cur_rem  <= new_rem;
                        cur_addr <= new_addr;
`ifdef DMA_ARB_INTERLEAVE_EN
                        slot_rem[owner]  <= new_rem;
                        slot_addr[owner] <= new_addr;
`endif
                        if (cur_rem == BLK_W'(1)) begin
                            done  <= grant;
                            grant <= '0;
                            state <= IDLE;
`ifdef DMA_ARB_INTERLEAVE_EN
                            slot_active[owner] <= 1'b0;
`endif
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // Arbitration overrides the per-state defaults above when it picks a winner.
            if (arb_point && found) begin
                state <= ISSUE;
                grant <= win_hot;
                last  <= win;
`ifdef DMA_ARB_INTERLEAVE_EN
                owner <= win;
                if (!cont) begin
                    if (slot_active[win] && !fin_mask[win]) begin
                        cur_addr <= slot_addr[win];
                        cur_rem  <= slot_rem[win];
                    end else begin
                        ready            <= win_hot;
                        slot_active[win] <= 1'b1;
                        slot_addr[win]   <= win_addr;
                        slot_rem[win]    <= win_nblk;
                        cur_addr         <= win_addr;
                        cur_rem          <= win_nblk;
                    end
                end
`else
                ready    <= win_hot;
                cur_addr <= win_addr;
                cur_rem  <= win_nblk;
`endif
            end
        end
    end

    assign bus.o_req_ready  = ready;
    assign bus.o_req_done   = done;
    assign bus.o_grant      = grant;
    assign bus.o_busy       = (state != IDLE);
    assign bus.o_start_dma  = (state == ISSUE) && (cur_rem != '0);
    assign bus.o_start_addr = cur_addr;
    assign bus.o_num_trans  = BITS_TRANS'(NUM_TRANS);
endmodule

// File: tb/tb_dma_rd_arbiter.sv
// Directed self-checking bench for dma_rd_arbiter with hand-computed expectations.
// The interleave scenario is only exercised when DMA_ARB_INTERLEAVE_EN is defined.
module tb_dma_rd_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   passed = 0;

    dma_rd_arbiter_if #(.NUM_REQ(4), .AW(32), .BITS_TRANS(8), .BLK_W(16)) bus ();

    dma_rd_arbiter #(
        .NUM_REQ(4), .AW(32), .BITS_TRANS(8), .NUM_TRANS(16),
        .BYTES_PER_BEAT(4), .BLK_W(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_done();
        bus.i_dma_done = 1'b1;
        tick();
        bus.i_dma_done = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [15:0] n);
        bus.i_req_addr[i*32 +: 32] = a;
        bus.i_req_nblk[i*16 +: 16] = n;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (bus.o_req_ready !== 4'b0) $display("[TB] FAIL reset_ready got %b exp 0000", bus.o_req_ready); else passed++;
        checks++; if (bus.o_req_done !== 4'b0) $display("[TB] FAIL reset_done got %b exp 0000", bus.o_req_done); else passed++;
        checks++; if (bus.o_grant !== 4'b0) $display("[TB] FAIL reset_grant got %b exp 0000", bus.o_grant); else passed++;
        checks++; if (bus.o_busy !== 1'b0 || bus.o_start_dma !== 1'b0) $display("[TB] FAIL reset_busy_start got %b%b exp 00", bus.o_busy, bus.o_start_dma); else passed++;
        checks++; if (bus.o_start_addr !== 32'h0) $display("[TB] FAIL reset_addr got %h exp 00000000", bus.o_start_addr); else passed++;
        checks++; if (bus.o_num_trans !== 8'd16) $display("[TB] FAIL reset_num_trans got %0d exp 16", bus.o_num_trans); else passed++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic [31:0] exp_addr;
        set_req(0, 32'h1000_0000, 16'd3);
        bus.i_req_valid = 4'b0001;
        tick();
        checks++; if (bus.o_req_ready !== 4'b0001) $display("[TB] FAIL single_ready got %b exp 0001", bus.o_req_ready); else passed++;
        bus.i_req_valid = 4'b0000;
        for (int b = 0; b < 3; b++) begin
            exp_addr = 32'h1000_0000 + 32'(b * 64);
            checks++; if (bus.o_start_dma !== 1'b1 || bus.o_start_addr !== exp_addr) $display("[TB] FAIL single_start%0d got %b/%h exp 1/%h", b, bus.o_start_dma, bus.o_start_addr, exp_addr); else passed++;
            tick();
            checks++; if (bus.o_start_dma !== 1'b0 || bus.o_grant !== 4'b0001) $display("[TB] FAIL single_wait%0d got start=%b grant=%b exp start=0 grant=0001", b, bus.o_start_dma, bus.o_grant); else passed++;
            tick();
            pulse_done();
        end
        checks++; if (bus.o_req_done !== 4'b0001 || bus.o_grant !== 4'b0) $display("[TB] FAIL single_done got done=%b grant=%b exp done=0001 grant=0000", bus.o_req_done, bus.o_grant); else passed++;
        tick();
        checks++; if (bus.o_req_done !== 4'b0 || bus.o_busy !== 1'b0) $display("[TB] FAIL single_idle got done=%b busy=%b exp 0000/0", bus.o_req_done, bus.o_busy); else passed++;
    endtask

    task automatic test_round_robin();
        int order [3] = '{0, 1, 3};
        int w;
        logic [3:0] hot;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 32'((i + 1) * 32'h100), 16'd1);
        for (int r = 0; r < 2; r++) begin
            bus.i_req_valid = 4'b1011;
            tick();
            for (int k = 0; k < 3; k++) begin
                w = order[k];
                hot = 4'(1 << w);
                checks++; if (bus.o_req_ready !== hot || bus.o_grant !== hot) $display("[TB] FAIL rr%0d_grant%0d got ready=%b grant=%b exp %b", r, k, bus.o_req_ready, bus.o_grant, hot); else passed++;
                checks++; if (bus.o_start_addr !== 32'((w + 1) * 32'h100)) $display("[TB] FAIL rr%0d_addr%0d got %h exp %h", r, k, bus.o_start_addr, 32'((w + 1) * 32'h100)); else passed++;
                bus.i_req_valid[w] = 1'b0;
                tick();
                pulse_done();
                checks++; if (bus.o_req_done !== hot || bus.o_grant !== 4'b0) $display("[TB] FAIL rr%0d_done%0d got done=%b grant=%b exp %b/0000", r, k, bus.o_req_done, bus.o_grant, hot); else passed++;
                if (k < 2) tick();
            end
        end
        tick();
    endtask

    task automatic test_zero_length();
        set_req(2, 32'h0000_5000, 16'd0);
        bus.i_req_valid = 4'b0100;
        tick();
        checks++; if (bus.o_req_ready !== 4'b0100 || bus.o_grant !== 4'b0100) $display("[TB] FAIL zero_accept got ready=%b grant=%b exp 0100", bus.o_req_ready, bus.o_grant); else passed++;
        checks++; if (bus.o_start_dma !== 1'b0) $display("[TB] FAIL zero_nostart1 got %b exp 0", bus.o_start_dma); else passed++;
        bus.i_req_valid = 4'b0000;
        tick();
        checks++; if (bus.o_req_done !== 4'b0100 || bus.o_start_dma !== 1'b0 || bus.o_grant !== 4'b0) $display("[TB] FAIL zero_done got done=%b start=%b grant=%b exp 0100/0/0000", bus.o_req_done, bus.o_start_dma, bus.o_grant); else passed++;
        tick();
        checks++; if (bus.o_busy !== 1'b0 || bus.o_req_done !== 4'b0) $display("[TB] FAIL zero_idle got busy=%b done=%b exp 0/0000", bus.o_busy, bus.o_req_done); else passed++;
    endtask

    task automatic test_wrap();
        set_req(0, 32'hFFFF_FFC0, 16'd2);
        bus.i_req_valid = 4'b0001;
        tick();
        bus.i_req_valid = 4'b0000;
        checks++; if (bus.o_start_addr !== 32'hFFFF_FFC0) $display("[TB] FAIL wrap_first got %h exp ffffffc0", bus.o_start_addr); else passed++;
        tick();
        pulse_done();
        checks++; if (bus.o_start_dma !== 1'b1 || bus.o_start_addr !== 32'h0) $display("[TB] FAIL wrap_second got %b/%h exp 1/00000000", bus.o_start_dma, bus.o_start_addr); else passed++;
        tick();
        pulse_done();
        checks++; if (bus.o_req_done !== 4'b0001) $display("[TB] FAIL wrap_done got %b exp 0001", bus.o_req_done); else passed++;
        tick();
    endtask

    task automatic test_spurious_and_reset();
        pulse_done();
        checks++; if (bus.o_busy !== 1'b0 || bus.o_grant !== 4'b0 || bus.o_start_dma !== 1'b0 || bus.o_req_done !== 4'b0) $display("[TB] FAIL spurious_done got busy=%b grant=%b start=%b done=%b exp all 0", bus.o_busy, bus.o_grant, bus.o_start_dma, bus.o_req_done); else passed++;
        set_req(1, 32'h0000_2000, 16'd4);
        bus.i_req_valid = 4'b0010;
        tick();
        bus.i_req_valid = 4'b0000;
        tick();
        checks++; if (bus.o_busy !== 1'b1 || bus.o_grant !== 4'b0010) $display("[TB] FAIL pre_reset_wait got busy=%b grant=%b exp 1/0010", bus.o_busy, bus.o_grant); else passed++;
        rst = 1'b1;
        #1;
        checks++; if (bus.o_busy !== 1'b0 || bus.o_grant !== 4'b0 || bus.o_start_addr !== 32'h0) $display("[TB] FAIL async_reset got busy=%b grant=%b addr=%h exp 0/0000/0", bus.o_busy, bus.o_grant, bus.o_start_addr); else passed++;
        tick();
        rst = 1'b0;
        set_req(1, 32'h0000_3000, 16'd1);
        bus.i_req_valid = 4'b0010;
        tick();
        bus.i_req_valid = 4'b0000;
        checks++; if (bus.o_req_ready !== 4'b0010 || bus.o_start_dma !== 1'b1 || bus.o_start_addr !== 32'h3000) $display("[TB] FAIL post_reset_start got ready=%b start=%b addr=%h exp 0010/1/00003000", bus.o_req_ready, bus.o_start_dma, bus.o_start_addr); else passed++;
        tick();
        pulse_done();
        checks++; if (bus.o_req_done !== 4'b0010) $display("[TB] FAIL post_reset_done got %b exp 0010", bus.o_req_done); else passed++;
        tick();
    endtask

`ifdef DMA_ARB_INTERLEAVE_EN
    task automatic test_interleave();
        logic [3:0]  exp_grant [4] = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
        logic [31:0] exp_addr  [4] = '{32'h1000, 32'h8000, 32'h1040, 32'h8040};
        logic [3:0]  exp_done  [4] = '{4'b0000, 4'b0000, 4'b0001, 4'b0010};
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(0, 32'h0000_1000, 16'd2);
        set_req(1, 32'h0000_8000, 16'd2);
        bus.i_req_valid = 4'b0011;
        tick();
        for (int b = 0; b < 4; b++) begin
            checks++; if (bus.o_grant !== exp_grant[b] || bus.o_start_addr !== exp_addr[b] || bus.o_start_dma !== 1'b1) $display("[TB] FAIL ilv_burst%0d got grant=%b addr=%h start=%b exp %b/%h/1", b, bus.o_grant, bus.o_start_addr, bus.o_start_dma, exp_grant[b], exp_addr[b]); else passed++;
            bus.i_req_valid = bus.i_req_valid & ~bus.o_req_ready;
            tick();
            pulse_done();
            checks++; if (bus.o_req_done !== exp_done[b]) $display("[TB] FAIL ilv_done%0d got %b exp %b", b, bus.o_req_done, exp_done[b]); else passed++;
        end
        checks++; if (bus.o_grant !== 4'b0) $display("[TB] FAIL ilv_final_grant got %b exp 0000", bus.o_grant); else passed++;
        tick();
    endtask
`endif

    initial begin
        rst             = 1'b1;
        bus.i_req_valid = '0;
        bus.i_req_addr  = '0;
        bus.i_req_nblk  = '0;
        bus.i_dma_done  = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_zero_length();
        test_wrap();
        test_spurious_and_reset();
`ifdef DMA_ARB_INTERLEAVE_EN
        test_interleave();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
